updown_counter_n: RTL and testbench

Parametrised synchronous up/down counter: the next generation of the 4-bit ripple counter. It replaces the ripple T-flip-flop chain with a single-clock binary register and adds configurable width and modulus, a parallel load, a one-shot mode and a terminal-count output for cascading. It is used as the general-purpose event and timer counter in the datapath, with Q optionally driven onto a shared bus.

---
 rtl/updown_counter_n_if.sv | 24 ++
 rtl/updown_counter_n.sv | 83 ++++++++
 tb/tb_updown_counter_n.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/updown_counter_n_if.sv
// rtl/updown_counter_n_if.sv - control, data and status bundle of the up/down counter
interface updown_counter_n_if #(
  parameter int WIDTH = 8
);
  logic             ENA;
  logic             UP_DOWN;
  logic             MODE;
  logic             LOAD;
  logic [WIDTH-1:0] DIN;
  logic             OE;
  logic [WIDTH-1:0] Q;
  logic             Z;
  logic             DONE;

  modport master (
    output ENA, UP_DOWN, MODE, LOAD, DIN, OE,
    input  Q, Z, DONE
  );

  modport slave (
    input  ENA, UP_DOWN, MODE, LOAD, DIN, OE,
    output Q, Z, DONE
  );
endinterface

// File: rtl/updown_counter_n.sv
// rtl/updown_counter_n.sv - parametrised modulo up/down counter with load, one-shot and terminal count; optional Q tristate via COUNTER_TRISTATE_EN
module updown_counter_n #(
  parameter int     WIDTH   = 8,
  parameter longint MODULUS = 256
) (
  input  logic                   CLK,
  input  logic                   RST,
  updown_counter_n_if.slave      bus
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  // MODULUS may equal 2^WIDTH, so the load comparison needs one extra bit.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_nxt;
  logic             done_q;
  logic             done_nxt;
  logic             tc;
  logic             z_int;
  logic [WIDTH-1:0] load_val;

  // Terminal count depends on direction; Z is the cascade enable for the next stage.
  always_comb begin
    load_val = ({1'b0, bus.DIN} < MOD_EXT) ? bus.DIN : CNT_MAX;
    tc       = bus.UP_DOWN ? (cnt == CNT_MAX) : (cnt == '0);
    z_int    = bus.ENA & tc & (state == RUN) & ~bus.LOAD;
  end

  // Next-state: load beats counting, counting only while running, halt on one-shot terminal count.
  always_comb begin
    cnt_nxt   = cnt;
    state_nxt = state;
    done_nxt  = 1'b0;
    if (bus.LOAD) begin
      cnt_nxt   = load_val;
      state_nxt = RUN;
    end else if ((state == RUN) && bus.ENA) begin
      if (z_int && bus.MODE) begin
        state_nxt = HALT;
        done_nxt  = 1'b1;
      end else if (bus.UP_DOWN) begin
        cnt_nxt = (cnt == CNT_MAX) ? '0 : cnt + ONE;
      end else begin
        cnt_nxt = (cnt == '0) ? CNT_MAX : cnt - ONE;
      end
    end
  end

  // State, count and DONE pulse registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state  <= RUN;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      done_q <= done_nxt;
    end
  end

  assign bus.Z    = z_int;
  assign bus.DONE = done_q;

`ifdef COUNTER_TRISTATE_EN
  // Only the output driver is gated; the count keeps running while Q floats.
  assign bus.Q = bus.OE ? cnt : {WIDTH{1'bz}};
`else
  logic unused_oe;
  assign unused_oe = bus.OE;
  assign bus.Q     = cnt;
`endif

endmodule

// File: tb/tb_updown_counter_n.sv
// tb/tb_updown_counter_n.sv - bench for updown_counter_n with WIDTH=4, MODULUS=10
module tb_updown_counter_n;

  localparam int W   = 4;
  localparam int MOD = 10;

  logic CLK;
  logic RST;
  int   total;
  int   bad;
  bit   check_en;

  int   m_cnt;
  bit   m_halt;
  bit   m_done;

  updown_counter_n_if #(.WIDTH(W)) bus ();

  updown_counter_n #(.WIDTH(W), .MODULUS(MOD)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: counter value as an integer with modulo arithmetic.
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_cnt  = 0;
      m_halt = 0;
      m_done = 0;
    end else if (bus.LOAD) begin
      m_cnt  = (int'(bus.DIN) < MOD) ? int'(bus.DIN) : MOD - 1;
      m_halt = 0;
      m_done = 0;
    end else if (!m_halt && bus.ENA) begin
      if (bus.MODE && (bus.UP_DOWN ? (m_cnt == MOD - 1) : (m_cnt == 0))) begin
        m_halt = 1;
        m_done = 1;
      end else begin
        m_done = 0;
        m_cnt  = bus.UP_DOWN ? (m_cnt + 1) % MOD : (m_cnt + MOD - 1) % MOD;
      end
    end else begin
      m_done = 0;
    end
  end

  function automatic bit model_z();
    return bus.ENA && !bus.LOAD && !m_halt &&
           (bus.UP_DOWN ? (m_cnt == MOD - 1) : (m_cnt == 0));
  endfunction

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge CLK) begin
    logic [W-1:0] exp_q;
    if (RST && check_en) begin
      exp_q = W'(m_cnt);
`ifdef COUNTER_TRISTATE_EN
      if (!bus.OE) exp_q = 'z;
`endif
      total++;
      if (bus.Q !== exp_q) begin
        bad++;
        $display("FAIL model_q t=%0t got=%b want=%b", $time, bus.Q, exp_q);
      end
      total++;
      if (bus.Z !== model_z()) begin
        bad++;
        $display("FAIL model_z t=%0t got=%b want=%b", $time, bus.Z, model_z());
      end
      total++;
      if (bus.DONE !== m_done) begin
        bad++;
        $display("FAIL model_done t=%0t got=%b want=%b", $time, bus.DONE, m_done);
      end
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%b want=%b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set(input bit ena, input bit up, input bit mode, input bit load, input int din);
    bus.ENA     = ena;
    bus.UP_DOWN = up;
    bus.MODE    = mode;
    bus.LOAD    = load;
    bus.DIN     = W'(din);
  endtask

  int up_seq   [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
  int down_seq [4]  = '{1, 0, 9, 8};

  initial begin
    total    = 0;
    bad      = 0;
    check_en = 0;
    RST      = 1'b0;
    bus.OE   = 1'b1;
    set(0, 1, 0, 0, 0);
    #2;
    chk("reset_q", bus.Q, 4'd0);
    chk("reset_z", 4'(bus.Z), 4'd0);
    chk("reset_done", 4'(bus.DONE), 4'd0);
    tick();
    RST      = 1'b1;
    check_en = 1;
    tick();
    chk("hold_after_reset", bus.Q, 4'd0);

    // Up count with wrap at 9.
    set(1, 1, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("up_q", bus.Q, 4'(up_seq[i]));
      chk("up_z", 4'(bus.Z), (up_seq[i] == 9) ? 4'd1 : 4'd0);
    end

    // Down count with wrap at 0.
    set(1, 0, 0, 1, 2);
    tick();
    chk("down_load", bus.Q, 4'd2);
    set(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("down_q", bus.Q, 4'(down_seq[i]));
      chk("down_z", 4'(bus.Z), (down_seq[i] == 0) ? 4'd1 : 4'd0);
    end

    // One-shot up from 7.
    set(1, 1, 1, 1, 7);
    tick();
    chk("os_load", bus.Q, 4'd7);
    set(1, 1, 1, 0, 0);
    tick();
    chk("os_8", bus.Q, 4'd8);
    tick();
    chk("os_9", bus.Q, 4'd9);
    chk("os_z_at_tc", 4'(bus.Z), 4'd1);
    tick();
    chk("os_hold", bus.Q, 4'd9);
    chk("os_done", 4'(bus.DONE), 4'd1);
    chk("os_halt_z", 4'(bus.Z), 4'd0);
    set(1, 0, 0, 0, 0);
    tick();
    chk("os_still_halt", bus.Q, 4'd9);
    chk("os_done_once", 4'(bus.DONE), 4'd0);
    chk("os_halt_z_down", 4'(bus.Z), 4'd0);
    set(1, 1, 1, 1, 3);
    tick();
    chk("os_reload", bus.Q, 4'd3);
    set(1, 1, 1, 0, 0);
    tick();
    chk("os_resume", bus.Q, 4'd4);

    // Load clamp and load priority at terminal count.
    set(0, 1, 1, 1, 12);
    tick();
    chk("clamp", bus.Q, 4'd9);
    set(1, 1, 1, 0, 0);
    #1;
    chk("tc_z", 4'(bus.Z), 4'd1);
    set(1, 1, 1, 1, 4);
    #1;
    chk("load_masks_z", 4'(bus.Z), 4'd0);
    tick();
    chk("load_wins", bus.Q, 4'd4);
    chk("load_no_done", 4'(bus.DONE), 4'd0);

    // Asynchronous reset between edges.
    set(0, 1, 0, 1, 5);
    tick();
    chk("pre_reset", bus.Q, 4'd5);
    set(0, 1, 0, 0, 0);
    #2;
    RST = 1'b0;
    #1;
    chk("async_reset", bus.Q, 4'd0);
    RST = 1'b1;
    tick();
    tick();
    chk("reset_hold", bus.Q, 4'd0);
    set(1, 1, 0, 0, 0);
    tick();
    chk("resume_count", bus.Q, 4'd1);

    // Output enable: count runs on while Q may float.
    set(1, 1, 0, 1, 0);
    tick();
    set(1, 1, 0, 0, 0);
    bus.OE = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
`ifdef COUNTER_TRISTATE_EN
      chk("oe_off_q", bus.Q, 4'bzzzz);
`else
      chk("oe_ignored_q", bus.Q, 4'(i));
`endif
    end
    set(0, 1, 0, 0, 0);
    bus.OE = 1'b1;
    #1;
    chk("oe_restored", bus.Q, 4'd4);
    tick();
    tick();

    check_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
